// File: rtl/tmu_pointgen.sv
// tmu_pointgen: walks a destination rectangle and emits (X,Y,U,V) points with DDA-interpolated texture coordinates
module tmu_pointgen #(
  parameter int COORD_W = 11,
  parameter int FRAC_W  = 6
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  input  logic [COORD_W-1:0]        x0,
  input  logic [COORD_W-1:0]        y0,
  input  logic [COORD_W-1:0]        width,
  input  logic [COORD_W-1:0]        height,
  input  logic [COORD_W-1:0]        u0,
  input  logic [COORD_W-1:0]        v0,
  input  logic [COORD_W+FRAC_W-1:0] du_x,
  input  logic [COORD_W+FRAC_W-1:0] dv_x,
  input  logic [COORD_W+FRAC_W-1:0] du_y,
  input  logic [COORD_W+FRAC_W-1:0] dv_y,
  output logic                      pipe_stb_o,
  input  logic                      pipe_ack_i,
  output logic [COORD_W-1:0]        P_X,
  output logic [COORD_W-1:0]        P_Y,
  output logic [COORD_W-1:0]        P_U,
  output logic [COORD_W-1:0]        P_V
);
  localparam int AW = COORD_W + FRAC_W;
  localparam logic [COORD_W-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [COORD_W-1:0] col, row, w_r, h_r, x0_r;
  logic [AW-1:0] u, v, urow, vrow, dux_r, dvx_r, duy_r, dvy_r;
  logic xfer, last_col, last_row, go;
  assign xfer = pipe_stb_o & pipe_ack_i;
  assign last_col = col == w_r - ONE;
  assign last_row = row == h_r - ONE;
  assign go = state == IDLE && start;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign P_U = u[AW-1:FRAC_W];
  assign P_V = v[AW-1:FRAC_W];
  // An empty rectangle still spends one RUN cycle with stb low before DONE
  always_comb begin
    state_nx = abort ? IDLE
             : go ? RUN
             : (state == RUN && (!pipe_stb_o || (xfer && last_col && last_row))) ? DONE
             : state == DONE ? IDLE
             : state;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pipe_stb_o <= 1'b0;
      {col, row, w_r, h_r, x0_r, P_X, P_Y} <= '0;
      {u, v, urow, vrow, dux_r, dvx_r, duy_r, dvy_r} <= '0;
    end else if (abort) begin
      pipe_stb_o <= 1'b0;
    end else if (go) begin
      pipe_stb_o <= width != '0 && height != '0;
      {col, row} <= '0;
      {w_r, h_r, x0_r, P_X, P_Y} <= {width, height, x0, x0, y0};
      {dux_r, dvx_r, duy_r, dvy_r} <= {du_x, dv_x, du_y, dv_y};
      u <= {u0, {FRAC_W{1'b0}}};
      urow <= {u0, {FRAC_W{1'b0}}};
      v <= {v0, {FRAC_W{1'b0}}};
      vrow <= {v0, {FRAC_W{1'b0}}};
    end else if (xfer && state == RUN) begin
      if (last_col && last_row) begin
        pipe_stb_o <= 1'b0;
      end else if (last_col) begin
        col <= '0;
        row <= row + ONE;
        P_X <= x0_r;
        P_Y <= P_Y + ONE;
        urow <= urow + duy_r;
        vrow <= vrow + dvy_r;
        u <= urow + duy_r;
        v <= vrow + dvy_r;
      end else begin
        col <= col + ONE;
        P_X <= P_X + ONE;
        u <= u + dux_r;
        v <= v + dvx_r;
      end
    end
  end
endmodule
